// File: rtl/masked_aes_session_ctrl.sv
// Session controller for a masked AES core: seed/reseed sequencing, encryption
// budget tracking, share-layout conversion and a small ciphertext output FIFO.
module masked_aes_session_ctrl #(
  parameter int unsigned d            = 2,
  parameter int unsigned SEED_W       = 80,
  parameter int unsigned RESEED_LIMIT = 1024,
  parameter int unsigned OUT_DEPTH    = 2,
  localparam int unsigned CW = (RESEED_LIMIT == 0) ? 1 : $clog2(RESEED_LIMIT + 1),
  localparam int unsigned W  = 128 * d
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_shares_plaintext,
  input  logic [W-1:0]      in_shares_key,
  input  logic              in_seed_valid,
  output logic              in_seed_ready,
  input  logic [SEED_W-1:0] in_seed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_shares_ciphertext,
  output logic              core_valid_in,
  input  logic              core_in_ready,
  output logic [W-1:0]      core_sh_plaintext,
  output logic [W-1:0]      core_sh_key,
  input  logic              core_busy,
  input  logic              core_cipher_valid,
  output logic              core_out_ready,
  input  logic [W-1:0]      core_sh_ciphertext,
  output logic              prng_start_reseed,
  output logic [SEED_W-1:0] prng_seed,
  input  logic              prng_out_valid,
  input  logic              prng_busy,
  output logic              need_reseed,
  output logic [CW-1:0]     enc_count
);

  localparam int unsigned PW = $clog2(OUT_DEPTH);

  typedef enum logic [1:0] {
    S_UNSEEDED,
    S_READY,
    S_RESEEDING,
    S_LOCKED
  } state_t;

  state_t      state_q, state_d;
  logic        busy_seen_q;
  logic        accept;
  logic        reseed_start;
  logic        reseed_done;
  logic        limit_hit;

  logic [W-1:0]  mem [OUT_DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  logic [W-1:0]  head;

  // Share-major <-> bit-major layout conversion
  for (genvar j = 0; j < d; j++) begin : g_share
    for (genvar i = 0; i < 128; i++) begin : g_bit
      assign core_sh_plaintext[d*i+j]      = in_shares_plaintext[128*j+i];
      assign core_sh_key[d*i+j]            = in_shares_key[128*j+i];
      assign out_shares_ciphertext[128*j+i] = head[d*i+j];
    end
  end

  assign prng_seed = in_seed;

  // Next-state and handshake decode
  always_comb begin
    state_d           = state_q;
    in_ready          = 1'b0;
    core_valid_in     = 1'b0;
    accept            = 1'b0;
    reseed_start      = 1'b0;
    reseed_done       = 1'b0;
    in_seed_ready     = 1'b0;
    prng_start_reseed = 1'b0;
    need_reseed       = 1'b0;
    limit_hit         = (RESEED_LIMIT != 0) && (enc_count == CW'(RESEED_LIMIT - 1));

    in_ready      = (state_q == S_READY) & core_in_ready & prng_out_valid;
    core_valid_in = in_ready & in_valid;
    accept        = core_valid_in;
    need_reseed   = (state_q == S_UNSEEDED) | (state_q == S_LOCKED);

    reseed_start = in_seed_valid & ~core_busy & (state_q != S_RESEEDING) &
                   ((state_q != S_READY) | ~in_valid);
    reseed_done  = (state_q == S_RESEEDING) & ~prng_busy & busy_seen_q;

    in_seed_ready     = reseed_start;
    prng_start_reseed = reseed_start;

    case (state_q)
      S_UNSEEDED, S_LOCKED: begin
        if (reseed_start) state_d = S_RESEEDING;
      end
      S_READY: begin
        // Encryption wins over a concurrent seed; reseed_start already excludes in_valid
        if (accept && limit_hit)  state_d = S_LOCKED;
        else if (reseed_start)    state_d = S_RESEEDING;
      end
      S_RESEEDING: begin
        if (reseed_done) state_d = S_READY;
      end
      default: state_d = S_UNSEEDED;
    endcase
  end

  // State, budget counter and reseed-progress flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_UNSEEDED;
      enc_count   <= '0;
      busy_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (reseed_done)  enc_count <= '0;
      else if (accept)  enc_count <= enc_count + CW'(1);
      if (reseed_done)
        busy_seen_q <= 1'b0;
      else if (state_q == S_RESEEDING && prng_busy)
        busy_seen_q <= 1'b1;
    end
  end

  // Ciphertext FIFO; extra pointer bit distinguishes full from empty
  assign empty          = (wr_ptr == rd_ptr);
  assign full           = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign core_out_ready = ~full;
  assign push           = core_cipher_valid & ~full;
  assign out_valid      = ~empty;
  assign pop            = ~empty & out_ready;
  assign head           = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= core_sh_ciphertext;
  end

endmodule

// File: tb/tb_masked_aes_session_ctrl.sv
// Directed bench for masked_aes_session_ctrl: layout tables plus hand-written
// reseed, budget, priority, FIFO and reset sequences.
module tb_masked_aes_session_ctrl;
  localparam int unsigned D   = 2;
  localparam int unsigned SW  = 80;
  localparam int unsigned LIM = 3;
  localparam int unsigned OD  = 2;
  localparam int unsigned W   = 128 * D;
  localparam int unsigned CW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_shares_plaintext, in_shares_key;
  logic          in_seed_valid, in_seed_ready;
  logic [SW-1:0] in_seed;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_shares_ciphertext;
  logic          core_valid_in, core_in_ready;
  logic [W-1:0]  core_sh_plaintext, core_sh_key;
  logic          core_busy, core_cipher_valid, core_out_ready;
  logic [W-1:0]  core_sh_ciphertext;
  logic          prng_start_reseed;
  logic [SW-1:0] prng_seed;
  logic          prng_out_valid, prng_busy;
  logic          need_reseed;
  logic [CW-1:0] enc_count;

  masked_aes_session_ctrl #(
    .d(D), .SEED_W(SW), .RESEED_LIMIT(LIM), .OUT_DEPTH(OD)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_shares_plaintext(in_shares_plaintext), .in_shares_key(in_shares_key),
    .in_seed_valid(in_seed_valid), .in_seed_ready(in_seed_ready), .in_seed(in_seed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_shares_ciphertext(out_shares_ciphertext),
    .core_valid_in(core_valid_in), .core_in_ready(core_in_ready),
    .core_sh_plaintext(core_sh_plaintext), .core_sh_key(core_sh_key),
    .core_busy(core_busy), .core_cipher_valid(core_cipher_valid),
    .core_out_ready(core_out_ready), .core_sh_ciphertext(core_sh_ciphertext),
    .prng_start_reseed(prng_start_reseed), .prng_seed(prng_seed),
    .prng_out_valid(prng_out_valid), .prng_busy(prng_busy),
    .need_reseed(need_reseed), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  // Share-major index and its hand-computed bit-major counterpart (d=2)
  typedef struct {
    int sm;
    int bm;
  } map_t;
  map_t tbl[6];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] oh(input int k);
    logic [255:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  int bad;

  initial begin
    tbl[0] = '{sm: 128, bm: 1};
    tbl[1] = '{sm: 0,   bm: 0};
    tbl[2] = '{sm: 127, bm: 254};
    tbl[3] = '{sm: 255, bm: 255};
    tbl[4] = '{sm: 129, bm: 3};
    tbl[5] = '{sm: 5,   bm: 10};

    rst = 1'b1;
    in_valid = 1'b0; in_shares_plaintext = '0; in_shares_key = '0;
    in_seed_valid = 1'b0; in_seed = '0;
    out_ready = 1'b0;
    core_in_ready = 1'b1; core_busy = 1'b0;
    core_cipher_valid = 1'b0; core_sh_ciphertext = '0;
    prng_out_valid = 1'b1; prng_busy = 1'b0;

    @(negedge clk);
    tick();
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_in_seed_ready", in_seed_ready, 1'b0);
    chk1("rst_prng_start", prng_start_reseed, 1'b0);
    chk1("rst_core_valid_in", core_valid_in, 1'b0);
    chk1("rst_need_reseed", need_reseed, 1'b1);
    chk("rst_enc_count", 256'(enc_count), 256'(0));
    rst = 1'b0;
    tick();

    // Unseeded: no acceptance for 20 cycles
    in_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      #1;
      if (in_ready !== 1'b0 || core_valid_in !== 1'b0) bad++;
      tick();
    end
    chk("unseeded_in_ready_cycles", 256'(bad), 256'(0));
    chk1("unseeded_need_reseed", need_reseed, 1'b1);
    chk("unseeded_enc_count", 256'(enc_count), 256'(0));

    // Input layout conversion table
    for (int k = 0; k < 6; k++) begin
      in_shares_plaintext = oh(tbl[k].sm);
      in_shares_key       = oh(tbl[(k+1)%6].sm);
      #1;
      chk($sformatf("pt_layout_%0d", tbl[k].sm), core_sh_plaintext, oh(tbl[k].bm));
      chk($sformatf("key_layout_%0d", tbl[(k+1)%6].sm), core_sh_key, oh(tbl[(k+1)%6].bm));
    end
    tick();
    in_valid = 1'b0;

    // First seed; prng_busy held for 5 cycles after one idle cycle
    in_seed = SW'(16'h1234);
    in_seed_valid = 1'b1;
    #1;
    chk1("seed_ready_pulse", in_seed_ready, 1'b1);
    chk1("seed_prng_start", prng_start_reseed, 1'b1);
    chk("seed_value", 256'(prng_seed), 256'(16'h1234));
    tick();
    #1;
    chk1("reseeding_seed_ignored", in_seed_ready, 1'b0);
    chk1("reseeding_no_pulse", prng_start_reseed, 1'b0);
    chk1("reseeding_need_reseed", need_reseed, 1'b0);
    tick();
    #1;
    chk1("no_exit_before_busy", in_ready, 1'b0);
    prng_busy = 1'b1;
    bad = 0;
    repeat (5) begin
      #1;
      if (in_ready !== 1'b0 || prng_start_reseed !== 1'b0) bad++;
      tick();
    end
    chk("reseeding_busy_cycles", 256'(bad), 256'(0));
    prng_busy = 1'b0;
    in_seed_valid = 1'b0;
    #1;
    chk1("busy_fall_still_reseeding", in_ready, 1'b0);
    tick();
    #1;
    chk1("ready_in_ready", in_ready, 1'b1);
    chk1("ready_need_reseed", need_reseed, 1'b0);
    chk("ready_enc_count", 256'(enc_count), 256'(0));

    // Encryption budget, with stalls from core_in_ready and prng_out_valid
    in_valid = 1'b1;
    #1;
    chk1("enc1_core_valid_in", core_valid_in, 1'b1);
    tick();
    chk("enc_count_1", 256'(enc_count), 256'(1));
    core_in_ready = 1'b0;
    #1;
    chk1("stall_core_in_ready", in_ready, 1'b0);
    tick();
    chk("enc_count_hold_core", 256'(enc_count), 256'(1));
    core_in_ready = 1'b1;
    prng_out_valid = 1'b0;
    #1;
    chk1("stall_prng_out_valid", in_ready, 1'b0);
    tick();
    chk("enc_count_hold_prng", 256'(enc_count), 256'(1));
    prng_out_valid = 1'b1;
    tick();
    chk("enc_count_2", 256'(enc_count), 256'(2));
    tick();
    #1;
    chk("locked_enc_count", 256'(enc_count), 256'(3));
    chk1("locked_in_ready", in_ready, 1'b0);
    chk1("locked_core_valid_in", core_valid_in, 1'b0);
    chk1("locked_need_reseed", need_reseed, 1'b1);
    tick();
    chk("locked_enc_count_hold", 256'(enc_count), 256'(3));

    // Reseed out of LOCKED, first blocked by core_busy
    in_seed = SW'(16'hBEEF);
    in_seed_valid = 1'b1;
    core_busy = 1'b1;
    #1;
    chk1("locked_core_busy_no_start", prng_start_reseed, 1'b0);
    tick();
    chk1("locked_still_need_reseed", need_reseed, 1'b1);
    core_busy = 1'b0;
    #1;
    chk1("locked_start", prng_start_reseed, 1'b1);
    chk("locked_seed_value", 256'(prng_seed), 256'(16'hBEEF));
    tick();
    in_seed_valid = 1'b0;
    prng_busy = 1'b1;
    tick();
    prng_busy = 1'b0;
    tick();
    #1;
    chk("relock_ready_enc_count", 256'(enc_count), 256'(0));
    chk1("relock_ready_in_ready", in_ready, 1'b1);
    chk1("relock_need_reseed", need_reseed, 1'b0);

    // Encryption beats a concurrent seed in READY
    in_seed_valid = 1'b1;
    #1;
    chk1("prio_in_ready", in_ready, 1'b1);
    chk1("prio_no_start", prng_start_reseed, 1'b0);
    chk1("prio_no_seed_ready", in_seed_ready, 1'b0);
    tick();
    chk("prio_enc_count", 256'(enc_count), 256'(1));
    in_valid = 1'b0;
    core_busy = 1'b1;
    #1;
    chk1("prio_core_busy_no_start", prng_start_reseed, 1'b0);
    tick();
    core_busy = 1'b0;
    #1;
    chk1("prio_start_after_drop", prng_start_reseed, 1'b1);
    tick();
    in_seed_valid = 1'b0;
    prng_busy = 1'b1;
    tick();
    prng_busy = 1'b0;
    tick();
    #1;
    chk("prio_reseed_enc_count", 256'(enc_count), 256'(0));
    chk1("prio_reseed_in_ready", in_ready, 1'b1);

    // FIFO fill with out_ready low, then drain in order
    core_cipher_valid = 1'b1;
    core_sh_ciphertext = oh(1);
    #1;
    chk1("fifo_empty_core_out_ready", core_out_ready, 1'b1);
    chk1("fifo_no_passthrough", out_valid, 1'b0);
    tick();
    core_sh_ciphertext = oh(254);
    #1;
    chk1("fifo_one_out_valid", out_valid, 1'b1);
    chk("fifo_head_a", out_shares_ciphertext, oh(128));
    tick();
    core_sh_ciphertext = oh(3);
    #1;
    chk1("fifo_full_core_out_ready", core_out_ready, 1'b0);
    tick();
    core_cipher_valid = 1'b0;
    #1;
    chk("fifo_full_head_held", out_shares_ciphertext, oh(128));
    chk1("fifo_still_full", core_out_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("fifo_pop_a", out_shares_ciphertext, oh(128));
    tick();
    #1;
    chk("fifo_pop_b", out_shares_ciphertext, oh(127));
    tick();
    #1;
    chk1("fifo_drained", out_valid, 1'b0);

    // Simultaneous push and pop across the pointer wrap
    core_cipher_valid = 1'b1;
    core_sh_ciphertext = oh(3);
    #1;
    chk1("fifo_wrap_no_passthrough", out_valid, 1'b0);
    tick();
    core_sh_ciphertext = oh(0);
    #1;
    chk("fifo_head_d", out_shares_ciphertext, oh(129));
    tick();
    core_cipher_valid = 1'b0;
    #1;
    chk1("fifo_pushpop_valid", out_valid, 1'b1);
    chk1("fifo_pushpop_not_full", core_out_ready, 1'b1);
    chk("fifo_head_e", out_shares_ciphertext, oh(0));
    tick();
    #1;
    chk1("fifo_empty_again", out_valid, 1'b0);

    // Reset during a reseed with a ciphertext buffered
    out_ready = 1'b0;
    core_cipher_valid = 1'b1;
    core_sh_ciphertext = oh(5);
    tick();
    core_cipher_valid = 1'b0;
    in_seed = SW'(8'h55);
    in_seed_valid = 1'b1;
    #1;
    chk1("midrst_start", prng_start_reseed, 1'b1);
    chk1("midrst_buffered", out_valid, 1'b1);
    tick();
    in_seed_valid = 1'b0;
    prng_busy = 1'b1;
    rst = 1'b1;
    tick();
    prng_busy = 1'b0;
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_core_out_ready", core_out_ready, 1'b1);
    chk1("midrst_need_reseed", need_reseed, 1'b1);
    chk1("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_enc_count", 256'(enc_count), 256'(0));
    rst = 1'b0;
    tick();
    tick();
    #1;
    chk1("postrst_unseeded", in_ready, 1'b0);
    chk1("postrst_need_reseed", need_reseed, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/masked_aes_session_ctrl.md
MASKED_AES_SESSION_CTRL -- requirements
Module: masked_aes_session_ctrl

Interface
REQ-001 SHALL have parameter d, default 2: number of shares, d >= 2.
REQ-002 SHALL have parameter SEED_W, default 80: PRNG seed width.
REQ-003 SHALL have parameter RESEED_LIMIT, default 1024: encryptions allowed per seed; 0 = unlimited.
REQ-004 SHALL have parameter OUT_DEPTH, default 2: ciphertext FIFO entries, power of 2, >= 2.
REQ-005 SHALL have ports, in order:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid / in_ready  in / out  1  plaintext+key stream handshake.
- in_shares_plaintext, in_shares_key  in  128*d  share-major: share j of bit i at index 128*j+i.
- in_seed_valid / in_seed_ready  in / out  1  seed stream handshake.
- in_seed  in  SEED_W  seed.
- out_valid / out_ready  out / in  1  ciphertext stream handshake.
- out_shares_ciphertext  out  128*d  share-major ciphertext.
- core_valid_in / core_in_ready  out / in  1  core input handshake.
- core_sh_plaintext, core_sh_key  out  128*d  bit-major: share j of bit i at index d*i+j.
- core_busy  in  1  core active.
- core_cipher_valid / core_out_ready  in / out  1  core output handshake.
- core_sh_ciphertext  in  128*d  bit-major ciphertext.
- prng_start_reseed  out  1  one-cycle reseed pulse.
- prng_seed  out  SEED_W  seed to PRNG.
- prng_out_valid, prng_busy  in  1  PRNG status.
- need_reseed  out  1  high in UNSEEDED or LOCKED.
- enc_count  out  max(1,$clog2(RESEED_LIMIT+1))  encryptions since last reseed.

Function
REQ-006 SHALL implement states UNSEEDED, READY, RESEEDING, LOCKED.
REQ-007 SHALL convert share-major to bit-major on input and bit-major to share-major on output, combinationally.
REQ-008 in_ready and core_valid_in SHALL be (state==READY) & core_in_ready & prng_out_valid, core_valid_in additionally ANDed with in_valid.
REQ-009 SHALL increment enc_count on each accepted encryption (in_valid & in_ready).
REQ-010 If RESEED_LIMIT != 0 and an acceptance brings enc_count to RESEED_LIMIT, SHALL go READY -> LOCKED on the next cycle.
REQ-011 If RESEED_LIMIT == 0, enc_count SHALL wrap modulo its width and LOCKED SHALL never be entered.
REQ-012 Reseed start condition SHALL be in_seed_valid & ~core_busy & state in {UNSEEDED, READY, LOCKED} & (state != READY | ~in_valid).
REQ-013 Encryption SHALL take priority over reseed in READY when in_valid and in_seed_valid are both high.
REQ-014 On reseed start, prng_start_reseed and in_seed_ready SHALL pulse high for exactly that cycle, prng_seed SHALL equal in_seed, and the next state SHALL be RESEEDING.
REQ-015 RESEEDING SHALL set an internal flag when prng_busy==1 and exit to READY in the first cycle with prng_busy==0 and the flag set.
REQ-016 On exiting RESEEDING, enc_count SHALL clear to 0 and the flag SHALL clear.
REQ-017 in_seed_valid SHALL be ignored while in RESEEDING.
REQ-018 SHALL buffer ciphertexts in an OUT_DEPTH-entry FIFO.
REQ-019 core_out_ready SHALL be ~full.
REQ-020 A push SHALL occur on core_cipher_valid & core_out_ready; there SHALL be no pass-through when full.
REQ-021 out_valid SHALL be ~empty, out_shares_ciphertext SHALL be the head entry, and a pop SHALL occur on out_valid & out_ready.
REQ-022 A pushed ciphertext SHALL appear at the output no earlier than the next cycle.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-024 Pointers SHALL wrap modulo OUT_DEPTH.
REQ-025 FIFO contents SHALL be held unchanged while out_ready is low.

Reset
REQ-026 On rst: state UNSEEDED, enc_count 0, FIFO empty, flag clear.
REQ-027 Reset values SHALL be out_valid 0, in_ready 0, in_seed_ready 0, prng_start_reseed 0, core_valid_in 0, need_reseed 1.
REQ-028 Reset mid-operation SHALL discard all FIFO contents and any in-progress reseed.

Verification
REQ-029 d=2, RESEED_LIMIT=3, OUT_DEPTH=2 for all scenarios below.
REQ-030 Reset, then in_valid=1 with no seed -> in_ready stays 0 for 20 cycles; need_reseed=1.
REQ-031 Seed 0x1234 with prng_busy high for 5 cycles -> one-cycle in_seed_ready/prng_start_reseed pulse with prng_seed=0x1234; READY after busy falls; need_reseed=0.
REQ-032 Three accepted encryptions -> enc_count=3; state LOCKED; in_ready=0; need_reseed=1; a new seed then restores READY with enc_count=0.
REQ-033 in_valid and in_seed_valid both high in READY -> encryption accepted, no reseed pulse; reseed starts once in_valid drops and core_busy=0.
REQ-034 out_ready=0 with 3 core ciphertexts offered -> 2 stored, core_out_ready=0; pops return them in order in share-major layout.
REQ-035 Plaintext bit 0 share 1 set (index 128) -> core_sh_plaintext index 1 set.
